stack_fifo_buf: RTL and testbench

- Parametrised successor to the single-mode stack controller: integrates storage and supports run-time LIFO or FIFO mode.
- Adds an exact occupancy count, programmable almost-full/almost-empty thresholds, a registered read path, and sticky overflow/underflow flags.
- Sits between a producer and a consumer in the same clock domain, as a drop-in operand/return buffer.

---
 rtl/stack_fifo_buf_pkg.sv | 19 +
 rtl/stack_fifo_buf_mem.sv | 38 +++
 rtl/stack_fifo_buf.sv | 162 ++++++++++++++++
 tb/tb_stack_fifo_buf.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/stack_fifo_buf_pkg.sv
// Shared encodings and sizing helpers for the stack/FIFO buffer.
package stack_fifo_buf_pkg;

  localparam logic MODE_LIFO = 1'b0;
  localparam logic MODE_FIFO = 1'b1;

  // Encoded as {push, pop}
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } op_e;

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/stack_fifo_buf_mem.sv
// Simple dual-port RAM: one write port, one registered read port.
// The array itself is not reset; only the read register is.
module stack_fifo_buf_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Same-address read and write returns the old word (replace-top relies on this)
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[raddr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/stack_fifo_buf.sv
// Run-time selectable LIFO/FIFO buffer with occupancy flags and sticky errors.
// Define STACK_FIFO_BUF_WATERMARK_EN to build the max_count high-watermark register.
module stack_fifo_buf
  import stack_fifo_buf_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = DEPTH * 3 / 4,
  parameter int AE_THRESH  = DEPTH / 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          mode,
  input  logic                          push,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          pop,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          rd_valid,
  output logic                          empty,
  output logic                          full,
  output logic                          almost_empty,
  output logic                          almost_full,
  output logic [cnt_width(DEPTH)-1:0]   count,
  output logic                          overflow,
  output logic                          underflow,
  output logic [cnt_width(DEPTH)-1:0]   max_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          mode_q, mode_d;
  logic          rd_valid_q, rd_valid_d;
  logic          overflow_q, overflow_d, underflow_q, underflow_d;

  logic          is_empty, is_full, is_fifo, push_acc, pop_acc;
  logic          mem_we, mem_re;
  logic [AW-1:0] mem_waddr, mem_raddr, top_idx, push_idx;
  op_e           op;

  assign op       = op_e'({push, pop});
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));
  assign is_fifo  = (mode_q == MODE_FIFO);
  assign top_idx  = AW'(count_q - CW'(1));
  assign push_idx = AW'(count_q);

  always_comb begin
    push_acc    = 1'b0;
    pop_acc     = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clear) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      unique case (op)
        OP_PUSH: if (!is_full) push_acc = 1'b1; else overflow_d = 1'b1;
        OP_POP:  if (!is_empty) pop_acc = 1'b1; else underflow_d = 1'b1;
        OP_BOTH: begin
          push_acc = 1'b1;
          if (is_empty) underflow_d = 1'b1;
          else          pop_acc     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    mode_d     = mode_q;
    rd_valid_d = pop_acc;
    mem_we     = push_acc;
    mem_re     = pop_acc;
    mem_raddr  = is_fifo ? rd_ptr_q : top_idx;
    // LIFO push+pop overwrites the current top rather than growing the stack
    mem_waddr  = is_fifo ? wr_ptr_q : (pop_acc ? top_idx : push_idx);

    if (push_acc && !pop_acc) count_d = count_q + CW'(1);
    if (pop_acc && !push_acc) count_d = count_q - CW'(1);
    if (is_fifo) begin
      if (push_acc) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_acc)  rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (is_empty && !push_acc) mode_d = mode;

    if (clear) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mode_q      <= MODE_LIFO;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mode_q      <= mode_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

`ifdef STACK_FIFO_BUF_WATERMARK_EN
  logic [CW-1:0] max_count_q, max_count_d;

  always_comb begin
    max_count_d = (count_d > max_count_q) ? count_d : max_count_q;
    if (clear) max_count_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) max_count_q <= '0;
    else       max_count_q <= max_count_d;
  end

  assign max_count = max_count_q;
`else
  assign max_count = '0;
`endif

  stack_fifo_buf_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (wr_data),
    .re    (mem_re),
    .raddr (mem_raddr),
    .rdata (rd_data)
  );

  assign rd_valid     = rd_valid_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  assign count        = count_q;
  assign empty        = is_empty;
  assign full         = is_full;
  assign almost_empty = (count_q <= CW'(AE_THRESH));
  assign almost_full  = (count_q >= CW'(AF_THRESH));

endmodule

// File: tb/tb_stack_fifo_buf.sv
// Directed plus random bench for stack_fifo_buf against a queue-based reference model.
module tb_stack_fifo_buf;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int CW    = 5;
  localparam int AF    = 12;
  localparam int AE    = 4;

  logic          clk = 1'b0;
  logic          reset, clear, mode, push, pop;
  logic [DW-1:0] wr_data, rd_data;
  logic          rd_valid, empty, full, almost_empty, almost_full, overflow, underflow;
  logic [CW-1:0] count, max_count;

  stack_fifo_buf #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .mode         (mode),
    .push         (push),
    .wr_data      (wr_data),
    .pop          (pop),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .max_count    (max_count)
  );

  always #5 clk = ~clk;

  // Reference model: contents as a queue, back = newest word
  logic [DW-1:0] q[$];
  logic          m_fifo, m_rv, m_ov, m_un;
  logic [DW-1:0] m_rd;
  int            m_max;
  int            passed = 0;
  int            total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    q.delete();
    m_fifo = 1'b0; m_rv = 1'b0; m_ov = 1'b0; m_un = 1'b0;
    m_rd = '0; m_max = 0;
  endtask

  task automatic model_step(input logic p, input logic pp, input logic [DW-1:0] d,
                            input logic md, input logic clr);
    int n;
    n    = q.size();
    m_rv = 1'b0;
    if (clr) begin
      q.delete();
      m_ov = 1'b0; m_un = 1'b0; m_max = 0;
    end else if (p && pp) begin
      if (n == 0) begin
        q.push_back(d);
        m_un = 1'b1;
      end else begin
        m_rv = 1'b1;
        if (m_fifo) begin
          m_rd = q.pop_front();
          q.push_back(d);
        end else begin
          m_rd = q[n-1];
          q[n-1] = d;
        end
      end
    end else if (p) begin
      if (n == DEPTH) m_ov = 1'b1;
      else            q.push_back(d);
    end else if (pp) begin
      if (n == 0) m_un = 1'b1;
      else begin
        m_rv = 1'b1;
        m_rd = m_fifo ? q.pop_front() : q.pop_back();
      end
    end
    if (n == 0 && !(p && !clr)) m_fifo = md;
    if (!clr && q.size() > m_max) m_max = q.size();
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("count",        32'(count),        32'(n));
    chk("empty",        32'(empty),        32'(n == 0));
    chk("full",         32'(full),         32'(n == DEPTH));
    chk("almost_empty", 32'(almost_empty), 32'(n <= AE));
    chk("almost_full",  32'(almost_full),  32'(n >= AF));
    chk("overflow",     32'(overflow),     32'(m_ov));
    chk("underflow",    32'(underflow),    32'(m_un));
    chk("rd_valid",     32'(rd_valid),     32'(m_rv));
    chk("rd_data",      32'(rd_data),      32'(m_rd));
`ifdef STACK_FIFO_BUF_WATERMARK_EN
    chk("max_count",    32'(max_count),    32'(m_max));
`else
    chk("max_count",    32'(max_count),    32'(0));
`endif
  endtask

  task automatic step(input logic p, input logic pp, input logic [DW-1:0] d,
                      input logic md, input logic clr);
    push = p; pop = pp; wr_data = d; mode = md; clear = clr;
    @(posedge clk);
    #1;
    model_step(p, pp, d, md, clr);
    check_all();
  endtask

  initial begin
    int pct_push, pct_pop;
    reset = 1'b1; clear = 1'b0; mode = 1'b0; push = 1'b0; pop = 1'b0; wr_data = '0;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    reset = 1'b0;

    // LIFO fill, overflow, drain, underflow, clear
    for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b0, DW'(i), 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'hEE, 1'b0, 1'b0);
    chk("ovf_hold_count", 32'(count), 32'(16));
    for (int i = DEPTH; i >= 1; i--) begin
      step(1'b0, 1'b1, '0, 1'b0, 1'b0);
      chk("lifo_drain", 32'(rd_data), 32'(i));
    end
    step(1'b0, 1'b1, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    chk("clear_ovf", 32'(overflow), 32'(0));

    // FIFO order with pointer wrap
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'hA0 + DW'(i), 1'b1, 1'b0);
    for (int i = 0; i < 5; i++)  step(1'b0, 1'b1, '0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'hB0 + DW'(i), 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 1'b1, '0, 1'b1, 1'b0);
      chk("fifo_order", 32'(rd_data), (i < 5) ? 32'(8'hA5 + i) : 32'(8'hB0 + i - 5));
    end

    // Mode lock and LIFO replace-top
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h22, 1'b1, 1'b0);
    step(1'b1, 1'b0, 8'h33, 1'b1, 1'b0);
    step(1'b1, 1'b1, 8'h44, 1'b1, 1'b0);
    chk("replace_top", 32'(rd_data), 32'(8'h33));
    step(1'b0, 1'b1, '0, 1'b1, 1'b0);
    chk("replace_pop", 32'(rd_data), 32'(8'h44));
    step(1'b0, 1'b1, '0, 1'b1, 1'b0);
    chk("lock_lifo", 32'(rd_data), 32'(8'h22));
    step(1'b0, 1'b1, '0, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 8'h55, 1'b1, 1'b0);
    chk("both_empty_un", 32'(underflow), 32'(1));
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);

    // Watermark then asynchronous reset mid-burst
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, DW'(i), 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, '0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 8'h77, 1'b1, 1'b0);
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    push = 1'b0;
    #1;
    reset = 1'b0;

    // Random traffic with shifting push/pop bias
    for (int i = 0; i < 600; i++) begin
      if (i % 100 == 0) begin
        pct_push = 30 + 20 * ((i / 100) % 3);
        pct_pop  = 100 - pct_push;
      end
      step($urandom_range(0, 99) < pct_push, $urandom_range(0, 99) < pct_pop,
           DW'($urandom), 1'($urandom), $urandom_range(0, 99) < 2);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
